if_id_queue: RTL and testbench
==============================

# if_id_queue

Parametrised IF→ID decoupling queue and successor to the single-entry IF/ID stall register. It holds up to DEPTH fetched instructions (PC, instruction word, exception type) and presents the oldest to ID with a valid/stall handshake. It gives fetch a registered-state `in_ready` credit instead of a one-shot next-PC pulse, and tags delay-slot instructions per dequeue. It sits between the AXI fetch unit and ID.

## Interface
- DEPTH, 2, entry count; power of two, ≥2
- ADDR_W, 32, PC width
- DATA_W, 32, instruction width
- EXC_W, 32, exception-type width
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- flush  in  1  exception flush; empties queue
- in_valid  in  1  fetch delivers in_pc/in_inst/in_exc this cycle
- in_pc  in  ADDR_W  fetched PC
- in_inst  in  DATA_W  fetched instruction
- in_exc  in  EXC_W  fetch-stage exception type
- in_ready  out  1  queue can accept; fetch may issue next request
- id_stall  in  1  ID stalled (stall[1]); head not consumed
- id_next_in_delay_slot  in  1  instruction ID accepts this cycle is a branch/jump
- out_valid  out  1  head entry valid
- out_pc  out  ADDR_W  head PC, 0 when !out_valid
- out_inst  out  DATA_W  head instruction, 0 when !out_valid
- out_exc  out  EXC_W  head exception type, 0 when !out_valid
- out_in_delay_slot  out  1  head is a delay-slot instruction
- count  out  $clog2(DEPTH+1)  occupancy

## Operation
- Circular buffer with wr_ptr/rd_ptr of $clog2(DEPTH) bits; both wrap modulo DEPTH. count is kept in a register.
- in_ready = !rst && (count < DEPTH). It does not depend on in_valid or id_stall.
- enq = in_valid && in_ready. It writes {in_pc, in_inst, in_exc} at wr_ptr and increments wr_ptr.
- If in_valid && !in_ready, the data is dropped. Fetch must not present data without credit; the bench asserts on this.
- deq = out_valid && !id_stall. It increments rd_ptr.
- count_next = count + enq − deq. Simultaneous enq and deq leaves count unchanged.
- out_valid = (count != 0). out_pc/out_inst/out_exc come from entry rd_ptr when valid and are forced to 0 otherwise, so ID sees a zero bubble.
- Delay-slot flag ds:
  - On deq, ds ← id_next_in_delay_slot.
  - With no deq, ds holds its value.
  - out_in_delay_slot = ds && out_valid.
  - The instruction dequeued after a branch therefore carries the tag regardless of how long it waited.
- Flush and reset: count, wr_ptr, rd_ptr and ds are cleared. in_valid and id_next_in_delay_slot are ignored in that cycle. Entry storage need not be cleared.
- Priority: rst > flush > enq/deq.

## Timing
- Reset values: out_valid=0, out_pc/out_inst/out_exc=0, out_in_delay_slot=0, count=0, in_ready=0 while rst is high.
- Latency: an entry enqueued in cycle N is visible on out_* in cycle N+1 when the queue was empty. Otherwise it appears after the older entries drain.
- Throughput: one enq and one deq per cycle, sustained.
- Full: in_ready falls in the cycle after the DEPTH-th enq. It rises in the cycle after the first deq.
- Flush with the queue full and id_stall=1: the next cycle has count=0, in_ready=1, out_valid=0.
- Reset mid-operation: same as flush, plus in_ready=0 during rst.

## Structure
- Constants `ZeroWord`, `Stop`/`NoStop`, `Valid`/`InValid` come from defines.v. No new typedefs are needed.
- Optional single sub-module `if_id_queue_mem`: DEPTH×(ADDR_W+DATA_W+EXC_W) register file with one write port and one read port. Pointer, count and ds logic stay in the top module.

## Test plan
1. Reset, then enq pc=0xBFC00000 inst=0x24080001 with id_stall=0 → next cycle out_valid=1, out_pc=0xBFC00000, count=1; following cycle out_valid=0, out_pc=0.
2. id_stall=1, DEPTH=2, enq 0x100 then 0x104 → count=2, in_ready=0. Release the stall → out_pc 0x100 then 0x104 on consecutive cycles, and in_ready=1 one cycle after the first deq.
3. Stream 0x200, 0x204, 0x208 with 0x200 a branch (id_next_in_delay_slot=1 during its deq), stall 3 cycles before 0x204 → out_in_delay_slot=1 only while 0x204 is head; 0 for 0x208.
4. Queue full plus in_valid=1 plus flush=1 → next cycle count=0, out_valid=0, ds=0; the flushed-cycle input is not stored.
5. Enq and deq in the same cycle at count=1 → count stays 1, out_pc advances to the new entry.
6. rst asserted with count=2 → in_ready=0 and all outputs 0 next cycle. After deassert, in_ready=1.

Source files
------------

// File: rtl/if_id_queue_pkg.sv
// rtl/if_id_queue_pkg.sv - shared constants for the IF->ID decoupling queue
//
// Purpose: constants used by if_id_queue and its storage.
// Ports: none (package).
package if_id_queue_pkg;

  localparam logic [31:0] ZeroWord = 32'h0000_0000;
  localparam logic        NoStop   = 1'b0;
  localparam logic        Valid    = 1'b1;
  localparam logic        InValid  = 1'b0;

endpackage

// File: rtl/if_id_queue_mem.sv
// rtl/if_id_queue_mem.sv - entry register file for the IF->ID queue
//
// Purpose: DEPTH x WIDTH storage, one synchronous write port, one
//          combinational read port. Contents are not reset.
// Ports:
//   clk    in   clock
//   we     in   write enable
//   waddr  in   write index
//   wdata  in   write data
//   raddr  in   read index
//   rdata  out  read data (combinational)
module if_id_queue_mem #(
  parameter int DEPTH  = 2,
  parameter int WIDTH  = 96,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/if_id_queue.sv
// rtl/if_id_queue.sv - IF->ID decoupling queue with delay-slot tagging
//
// Purpose: holds up to DEPTH fetched instructions and presents the oldest
//          to ID. Fetch gets a level credit (in_ready); ID consumes the head
//          whenever it is not stalled. The instruction dequeued after a
//          branch/jump is tagged as a delay-slot instruction.
// Ports:
//   clk, rst (sync, active-high), flush (empties queue)
//   in_valid/in_pc/in_inst/in_exc  fetch side, accepted when in_ready
//   in_ready                       credit to fetch
//   id_stall                       ID stalled, head held
//   id_next_in_delay_slot          instruction ID takes this cycle is a branch
//   out_valid/out_pc/out_inst/out_exc/out_in_delay_slot  head entry, zeroed when empty
//   count                          occupancy
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int EXC_W  = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [ADDR_W-1:0]          in_pc,
  input  logic [DATA_W-1:0]          in_inst,
  input  logic [EXC_W-1:0]           in_exc,
  output logic                       in_ready,
  input  logic                       id_stall,
  input  logic                       id_next_in_delay_slot,
  output logic                       out_valid,
  output logic [ADDR_W-1:0]          out_pc,
  output logic [DATA_W-1:0]          out_inst,
  output logic [EXC_W-1:0]           out_exc,
  output logic                       out_in_delay_slot,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int ENTRY_W = ADDR_W + DATA_W + EXC_W;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count_q;
  logic               ds_q;
  logic               enq;
  logic               deq;
  logic [ENTRY_W-1:0] rd_entry;

  // Credit depends only on registered occupancy, never on this cycle's
  // handshakes, so fetch can issue its next request off a clean signal.
  assign in_ready  = !rst && (count_q < FULL_CNT);
  assign out_valid = (count_q != '0) ? Valid : InValid;

  // A flushed cycle must not capture the incoming fetch data.
  assign enq = in_valid && in_ready && !flush;
  assign deq = out_valid && (id_stall == NoStop);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      ds_q    <= 1'b0;
    end else begin
      if (enq) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (deq) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
        // Tag sticks to whatever is dequeued next, however long it waits.
        ds_q   <= id_next_in_delay_slot;
      end
      if (enq && !deq) begin
        count_q <= count_q + CNT_W'(1);
      end else if (!enq && deq) begin
        count_q <= count_q - CNT_W'(1);
      end
    end
  end

  if_id_queue_mem #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W),
    .ADDR_W(PTR_W)
  ) u_mem (
    .clk  (clk),
    .we   (enq),
    .waddr(wr_ptr),
    .wdata({in_pc, in_inst, in_exc}),
    .raddr(rd_ptr),
    .rdata(rd_entry)
  );

  // ID sees an all-zero bubble when nothing is queued.
  assign out_pc   = out_valid ? rd_entry[ENTRY_W-1 -: ADDR_W]        : ADDR_W'(ZeroWord);
  assign out_inst = out_valid ? rd_entry[EXC_W+DATA_W-1 -: DATA_W]   : DATA_W'(ZeroWord);
  assign out_exc  = out_valid ? rd_entry[EXC_W-1:0]                  : EXC_W'(ZeroWord);

  assign out_in_delay_slot = ds_q && out_valid;
  assign count             = count_q;

endmodule

// File: tb/tb_if_id_queue.sv
// tb/tb_if_id_queue.sv - scoreboard bench for if_id_queue
module tb_if_id_queue;

  localparam int DEPTH = 2;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] exc;
  } entry_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_pc;
  logic [31:0] in_inst;
  logic [31:0] in_exc;
  logic        in_ready;
  logic        id_stall;
  logic        id_next_in_delay_slot;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic [31:0] out_exc;
  logic        out_in_delay_slot;
  logic [1:0]  count;

  int checks = 0;
  int errors = 0;

  entry_t exp_q[$];
  int     pend = 0;
  bit     ds_m = 1'b0;
  bit     chk_en = 1'b0;

  if_id_queue #(.DEPTH(DEPTH)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .flush                (flush),
    .in_valid             (in_valid),
    .in_pc                (in_pc),
    .in_inst              (in_inst),
    .in_exc               (in_exc),
    .in_ready             (in_ready),
    .id_stall             (id_stall),
    .id_next_in_delay_slot(id_next_in_delay_slot),
    .out_valid            (out_valid),
    .out_pc               (out_pc),
    .out_inst             (out_inst),
    .out_exc              (out_exc),
    .out_in_delay_slot    (out_in_delay_slot),
    .count                (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: mid-cycle, compare DUT state with the queue model, then retire
  // what the coming edge will consume or discard.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        int     cnt;
        entry_t h;
        cnt = exp_q.size() - pend;
        h   = '{pc: 32'h0, inst: 32'h0, exc: 32'h0};
        if (cnt > 0) h = exp_q[0];
        check("count",     64'(count),             64'(cnt));
        check("out_valid", 64'(out_valid),         64'(cnt != 0));
        check("in_ready",  64'(in_ready),          64'(!rst && cnt < DEPTH));
        check("out_pc",    64'(out_pc),            64'(h.pc));
        check("out_inst",  64'(out_inst),          64'(h.inst));
        check("out_exc",   64'(out_exc),           64'(h.exc));
        check("out_ds",    64'(out_in_delay_slot), 64'(ds_m && cnt != 0));
        if (rst || flush) begin
          exp_q.delete();
          ds_m = 1'b0;
        end else if (cnt != 0 && !id_stall) begin
          void'(exp_q.pop_front());
          ds_m = id_next_in_delay_slot;
        end
      end
    end
  end

  // One call per clock cycle; pushes the expected entry when the model grants credit.
  task automatic step(input bit iv, input logic [31:0] pc, input logic [31:0] inst,
                      input logic [31:0] exc, input bit st, input bit dsn,
                      input bit fl, input bit r);
    @(posedge clk);
    #1;
    rst                   = r;
    flush                 = fl;
    in_valid              = iv;
    in_pc                 = pc;
    in_inst               = inst;
    in_exc                = exc;
    id_stall              = st;
    id_next_in_delay_slot = dsn;
    pend                  = 0;
    if (iv && !r && exp_q.size() < DEPTH) begin
      exp_q.push_back('{pc: pc, inst: inst, exc: exc});
      pend = 1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_inst = '0; in_exc = '0;
    id_stall = 1'b0; id_next_in_delay_slot = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    step(0, 0, 0, 0, 0, 0, 0, 1);
    // 1: single instruction, one-cycle latency, then bubble
    step(1, 32'hBFC0_0000, 32'h2408_0001, 32'h0, 0, 0, 0, 0);
    idle(2);
    // 2: fill under stall, drain back to back
    step(1, 32'h100, 32'h1, 32'h0, 1, 0, 0, 0);
    step(1, 32'h104, 32'h2, 32'h0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0, 0);
    idle(3);
    // 3: delay-slot tag survives a 3-cycle stall
    step(1, 32'h200, 32'h3, 32'h0, 1, 0, 0, 0);
    step(1, 32'h204, 32'h4, 32'h0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0, 0);
    step(1, 32'h208, 32'h5, 32'h0, 0, 0, 0, 0);
    idle(2);
    // 4: flush while full with fetch data present
    step(1, 32'h300, 32'h6, 32'h7, 1, 0, 0, 0);
    step(1, 32'h304, 32'h8, 32'h9, 1, 1, 0, 0);
    step(1, 32'h308, 32'hA, 32'hB, 1, 1, 1, 0);
    idle(2);
    // 5: simultaneous enq/deq at count 1
    step(1, 32'h400, 32'hC, 32'h0, 1, 0, 0, 0);
    step(1, 32'h404, 32'hD, 32'h0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0, 0);
    idle(2);
    // 6: reset mid-operation
    step(1, 32'h500, 32'hE, 32'h0, 1, 1, 0, 0);
    step(1, 32'h504, 32'hF, 32'h0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0, 1);
    idle(2);
    // Randomized traffic, fetch only issues with credit
    for (int i = 0; i < 400; i++) begin
      bit iv;
      iv = ($urandom_range(0, 9) < 7) && (exp_q.size() < DEPTH);
      step(iv, $urandom, $urandom, $urandom_range(0, 15),
           $urandom_range(0, 9) < 4, $urandom_range(0, 9) < 3,
           $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 1);
    end
    idle(3);
    @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
